// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu_core slice.
//   - opcode_e / state_e enums
//   - instruction field slice constants
//   - flags_t and the branch-condition helper
//   - PROGRAM_ROM, the default 32-word program
package cpu_pkg;

  localparam int DATA_W = 16;

  // Instruction field positions.
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 11;
  localparam int RD_HI   = 10;
  localparam int RD_LO   = 8;
  localparam int RS1_HI  = 7;
  localparam int RS1_LO  = 5;
  localparam int RS2_HI  = 4;
  localparam int RS2_LO  = 2;
  localparam int IMM8_HI = 7;
  localparam int IMM5_HI = 4;

  typedef enum logic [4:0] {
    OP_ADD  = 5'h00,
    OP_SUB  = 5'h01,
    OP_AND  = 5'h02,
    OP_OR   = 5'h03,
    OP_XOR  = 5'h04,
    OP_NAND = 5'h05,
    OP_NOR  = 5'h06,
    OP_XNOR = 5'h07,
    OP_NOT  = 5'h08,
    OP_NEG  = 5'h09,
    OP_INC  = 5'h0A,
    OP_DEC  = 5'h0B,
    OP_MUL  = 5'h0C,
    OP_LSL  = 5'h0D,
    OP_ASR  = 5'h0E,
    OP_LSR  = 5'h0F,
    OP_LDI  = 5'h10,
    OP_MOV  = 5'h11,
    OP_CMP  = 5'h12,
    OP_BEQ  = 5'h13,
    OP_BNE  = 5'h14,
    OP_BLT  = 5'h15,
    OP_BGE  = 5'h16,
    OP_BRA  = 5'h17,
    OP_LD   = 5'h18,
    OP_ST   = 5'h19,
    OP_NOP  = 5'h1A
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
  } flags_t;

  // Branch decision; C holds the unsigned borrow of the last CMP.
  function automatic logic branch_taken(opcode_e op, flags_t f);
    case (op)
      OP_BEQ:  return f.z;
      OP_BNE:  return !f.z;
      OP_BLT:  return f.c;
      OP_BGE:  return !f.c;
      OP_BRA:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction encoders used to build the ROM image.
  function automatic logic [15:0] enc_r(logic [4:0] op, logic [2:0] rd,
                                        logic [2:0] rs1, logic [2:0] rs2);
    return {op, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic logic [15:0] enc_i(logic [4:0] op, logic [2:0] rd,
                                        logic [7:0] imm8);
    return {op, rd, imm8};
  endfunction

  function automatic logic [15:0] enc_b(logic [4:0] op, logic [4:0] imm5);
    return {op, 6'b000000, imm5};
  endfunction

  // Default program: loads, one pass over every ALU op into R7, a block of
  // branch tests whose fall-through paths write the poison value 1 into R7,
  // then a store/load round trip through DM[10]. Falls off 31 back to 0.
  localparam logic [15:0] PROGRAM_ROM [32] = '{
    enc_i(OP_LDI, 3'd2, 8'd5),      // 0  R2 = 5
    enc_i(OP_LDI, 3'd3, 8'd3),      // 1  R3 = 3
    enc_i(OP_LDI, 3'd4, 8'd8),      // 2  R4 = 8
    enc_i(OP_LDI, 3'd5, 8'd10),     // 3  R5 = 10
    enc_i(OP_LDI, 3'd6, 8'hA5),     // 4  R6 = 0x00A5
    enc_r(OP_ADD,  3'd7, 3'd2, 3'd3),
    enc_r(OP_SUB,  3'd7, 3'd2, 3'd3),
    enc_r(OP_AND,  3'd7, 3'd2, 3'd3),
    enc_r(OP_OR,   3'd7, 3'd2, 3'd3),
    enc_r(OP_XOR,  3'd7, 3'd2, 3'd3),
    enc_r(OP_NAND, 3'd7, 3'd2, 3'd3),
    enc_r(OP_NOR,  3'd7, 3'd2, 3'd3),
    enc_r(OP_XNOR, 3'd7, 3'd2, 3'd3),
    enc_r(OP_NOT,  3'd7, 3'd2, 3'd3),
    enc_r(OP_NEG,  3'd7, 3'd2, 3'd3),
    enc_r(OP_INC,  3'd7, 3'd2, 3'd3),
    enc_r(OP_DEC,  3'd7, 3'd2, 3'd3),
    enc_r(OP_MUL,  3'd7, 3'd2, 3'd3),
    enc_r(OP_LSL,  3'd7, 3'd6, 3'd4), // 18 R7 = 0xA500 (negative for ASR)
    enc_r(OP_ASR,  3'd7, 3'd7, 3'd3), // 19
    enc_r(OP_LSR,  3'd7, 3'd7, 3'd3), // 20
    enc_r(OP_CMP,  3'd0, 3'd3, 3'd2), // 21 3-5: Z=0, C=1
    enc_b(OP_BNE, 5'd24),           // 22 taken
    enc_i(OP_LDI, 3'd7, 8'd1),      // 23 poison
    enc_b(OP_BLT, 5'd26),           // 24 taken
    enc_i(OP_LDI, 3'd7, 8'd1),      // 25 poison
    enc_b(OP_BGE, 5'd23),           // 26 not taken
    enc_r(OP_CMP,  3'd0, 3'd2, 3'd2), // 27 5-5: Z=1, C=0
    enc_b(OP_BEQ, 5'd30),           // 28 taken
    enc_i(OP_LDI, 3'd7, 8'd1),      // 29 poison
    enc_r(OP_ST,   3'd0, 3'd5, 3'd4), // 30 DM[R5] = R4
    enc_r(OP_LD,   3'd7, 3'd5, 3'd0)  // 31 R7 = DM[R5]
  };

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational 16-bit ALU for opcodes 0x00-0x0F.
//   op : low four opcode bits
//   a  : rs1 operand
//   b  : rs2 operand (shifts use b[3:0])
//   y  : result, modulo 2^16
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0] a_s;
  logic        [3:0]        shamt;

  assign a_s   = a;
  assign shamt = b[3:0];

  always_comb begin
    y = '0;
    case (op)
      4'h0: y = a + b;
      4'h1: y = a - b;
      4'h2: y = a & b;
      4'h3: y = a | b;
      4'h4: y = a ^ b;
      4'h5: y = ~(a & b);
      4'h6: y = ~(a | b);
      4'h7: y = ~(a ^ b);
      4'h8: y = ~a;
      4'h9: y = -a;
      4'hA: y = a + 16'd1;
      4'hB: y = a - 16'd1;
      4'hC: y = a * b;
      4'hD: y = a << shamt;
      4'hE: y = a_s >>> shamt;
      4'hF: y = a >> shamt;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// cpu_core: multi-cycle 16-bit load/store CPU, one instruction per 4 clocks
// (FETCH, DECODE, EXECUTE, WRITEBACK). Program comes from cpu_pkg::PROGRAM_ROM.
//   clock     : rising-edge clock
//   reset     : asynchronous, active-low; clears PC, FSM, R0-R7, flags, read_data
//   read_data : last word read from data RAM by LD
//   r7_data   : current contents of R7
//   PC_out    : current program counter
module cpu_core
  import cpu_pkg::*;
#(
  parameter int PM_WORDS = 32,
  parameter int DM_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] read_data,
  output logic [15:0] r7_data,
  output logic [4:0]  PC_out
);

  localparam int PC_W  = $clog2(PM_WORDS);
  localparam int DM_AW = $clog2(DM_WORDS);

  state_e            state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] regs [8];
  flags_t            flags;

  logic [DATA_W-1:0] ir_p0;
  logic [DATA_W-1:0] opa_p1;
  logic [DATA_W-1:0] opb_p1;
  logic [DATA_W-1:0] alu_p2;
  logic [DATA_W-1:0] dm [DM_WORDS];

  opcode_e           opc;
  logic [2:0]        rd;
  logic [2:0]        rs1;
  logic [2:0]        rs2;
  logic [7:0]        imm8;
  logic [4:0]        imm5;
  logic              is_alu;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W:0]   cmp_diff;

  assign opc    = opcode_e'(ir_p0[OPC_HI:OPC_LO]);
  assign rd     = ir_p0[RD_HI:RD_LO];
  assign rs1    = ir_p0[RS1_HI:RS1_LO];
  assign rs2    = ir_p0[RS2_HI:RS2_LO];
  assign imm8   = ir_p0[IMM8_HI:0];
  assign imm5   = ir_p0[IMM5_HI:0];
  assign is_alu = ~ir_p0[OPC_HI];

  // Extra top bit captures the unsigned borrow of rs1 - rs2.
  assign cmp_diff = {1'b0, opa_p1} - {1'b0, opb_p1};

  cpu_alu u_alu (
    .op (ir_p0[OPC_LO+3:OPC_LO]),
    .a  (opa_p1),
    .b  (opb_p1),
    .y  (alu_y)
  );

  // Datapath registers and data RAM: no reset, only loaded in their stage.
  always_ff @(posedge clock) begin
    case (state)
      // FETCH -> instruction register
      S_FETCH: ir_p0 <= PROGRAM_ROM[pc];
      // DECODE -> operand registers
      S_DECODE: begin
        opa_p1 <= regs[rs1];
        opb_p1 <= regs[rs2];
      end
      // EXECUTE -> ALU result and store
      S_EXECUTE: begin
        alu_p2 <= alu_y;
        if (opc == OP_ST) dm[opa_p1[DM_AW-1:0]] <= opb_p1;
      end
      default: ;
    endcase
  end

  // Control FSM, program counter, flags, register file and read_data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= '0;
      flags     <= '0;
      read_data <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          pc    <= pc + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: begin
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (opc == OP_CMP) begin
            flags.z <= (cmp_diff[DATA_W-1:0] == '0);
            flags.n <= cmp_diff[DATA_W-1];
            flags.c <= cmp_diff[DATA_W];
          end
          if (branch_taken(opc, flags)) pc <= imm5;
          if (opc == OP_LD) read_data <= dm[opa_p1[DM_AW-1:0]];
          state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (is_alu) begin
            regs[rd] <= alu_p2;
          end else begin
            case (opc)
              OP_LDI:  regs[rd] <= {8'h00, imm8};
              OP_MOV:  regs[rd] <= opa_p1;
              OP_LD:   regs[rd] <= read_data;
              default: ;
            endcase
          end
          state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign r7_data = regs[7];
  assign PC_out  = pc;

endmodule

// File: tb/tb_cpu_core.sv
module tb_cpu_core;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] read_data;
  logic [15:0] r7_data;
  logic [4:0]  PC_out;

  int tests = 0;
  int fails = 0;

  cpu_core dut (
    .clock     (clock),
    .reset     (reset),
    .read_data (read_data),
    .r7_data   (r7_data),
    .PC_out    (PC_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  pc;
    logic [15:0] r7;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl [30];

  task automatic check(input string name, input int idx,
                       input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected state after each instruction's WRITEBACK edge (edge 4n+4).
    tbl[0]  = '{5'd1,  16'h0000, 16'h0000}; // LDI R2,#5
    tbl[1]  = '{5'd2,  16'h0000, 16'h0000}; // LDI R3,#3
    tbl[2]  = '{5'd3,  16'h0000, 16'h0000}; // LDI R4,#8
    tbl[3]  = '{5'd4,  16'h0000, 16'h0000}; // LDI R5,#10
    tbl[4]  = '{5'd5,  16'h0000, 16'h0000}; // LDI R6,#A5
    tbl[5]  = '{5'd6,  16'h0008, 16'h0000}; // ADD  5+3
    tbl[6]  = '{5'd7,  16'h0002, 16'h0000}; // SUB  5-3
    tbl[7]  = '{5'd8,  16'h0001, 16'h0000}; // AND
    tbl[8]  = '{5'd9,  16'h0007, 16'h0000}; // OR
    tbl[9]  = '{5'd10, 16'h0006, 16'h0000}; // XOR
    tbl[10] = '{5'd11, 16'hFFFE, 16'h0000}; // NAND
    tbl[11] = '{5'd12, 16'hFFF8, 16'h0000}; // NOR
    tbl[12] = '{5'd13, 16'hFFF9, 16'h0000}; // XNOR
    tbl[13] = '{5'd14, 16'hFFFA, 16'h0000}; // NOT 5
    tbl[14] = '{5'd15, 16'hFFFB, 16'h0000}; // NEG 5
    tbl[15] = '{5'd16, 16'h0006, 16'h0000}; // INC 5
    tbl[16] = '{5'd17, 16'h0004, 16'h0000}; // DEC 5
    tbl[17] = '{5'd18, 16'h000F, 16'h0000}; // MUL 5*3
    tbl[18] = '{5'd19, 16'hA500, 16'h0000}; // LSL 0xA5 by 8
    tbl[19] = '{5'd20, 16'hF4A0, 16'h0000}; // ASR 0xA500 by 3
    tbl[20] = '{5'd21, 16'h1E94, 16'h0000}; // LSR 0xF4A0 by 3
    tbl[21] = '{5'd22, 16'h1E94, 16'h0000}; // CMP R3,R2
    tbl[22] = '{5'd24, 16'h1E94, 16'h0000}; // BNE taken -> 24
    tbl[23] = '{5'd26, 16'h1E94, 16'h0000}; // BLT taken -> 26
    tbl[24] = '{5'd27, 16'h1E94, 16'h0000}; // BGE not taken
    tbl[25] = '{5'd28, 16'h1E94, 16'h0000}; // CMP R2,R2
    tbl[26] = '{5'd30, 16'h1E94, 16'h0000}; // BEQ taken -> 30
    tbl[27] = '{5'd31, 16'h1E94, 16'h0000}; // ST [R5],R4
    tbl[28] = '{5'd0,  16'h0008, 16'h0008}; // LD R7,[R5]; PC wraps
    tbl[29] = '{5'd1,  16'h0008, 16'h0008}; // LDI R2 again

    // Reset held across one clock edge.
    reset = 1'b0;
    tick();
    check("rst_pc", 0, {11'd0, PC_out}, 16'd0);
    check("rst_r7", 0, r7_data, 16'd0);
    check("rst_rd", 0, read_data, 16'd0);

    @(negedge clock);
    reset = 1'b1;

    for (int n = 0; n < 30; n++) begin
      repeat (4) tick();
      check("pc", n, {11'd0, PC_out}, {11'd0, tbl[n].pc});
      check("r7", n, r7_data, tbl[n].r7);
      check("read_data", n, read_data, tbl[n].rd);
    end

    // Fetch and decode of the next instruction; the FSM is now in EXECUTE.
    tick();
    check("mid_pc_fetch", 0, {11'd0, PC_out}, 16'd2);
    tick();
    check("mid_pre_r7", 0, r7_data, 16'h0008);
    check("mid_pre_rd", 0, read_data, 16'h0008);

    // Asynchronous reset between edges clears state without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("async_pc", 0, {11'd0, PC_out}, 16'd0);
    check("async_r7", 0, r7_data, 16'd0);
    check("async_rd", 0, read_data, 16'd0);
    tick();
    check("held_pc", 0, {11'd0, PC_out}, 16'd0);

    @(negedge clock);
    reset = 1'b1;
    tick();
    check("restart_pc_e1", 0, {11'd0, PC_out}, 16'd1);
    repeat (24) tick();
    check("restart_pc_e25", 0, {11'd0, PC_out}, 16'd7);
    check("restart_r7_e25", 0, r7_data, 16'h0008);
    check("restart_rd_e25", 0, read_data, 16'h0000);
    repeat (3) tick();
    check("restart_r7_sub", 0, r7_data, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
